// File: rtl/axis_read_interface_if.sv
// AXI-Stream beat channel carried between the BRAM read stage and its consumer.
`timescale 1ns/1ps
interface axis_read_interface_if #(
    parameter int data_width = 512,
    parameter int keep_width = data_width / 8
);
    logic                  t_valid;
    logic                  t_ready;
    logic [data_width-1:0] t_data;
    logic                  t_last;
    logic [keep_width-1:0] t_keep;

    modport master (output t_valid, t_data, t_last, t_keep, input t_ready);
    modport slave  (input t_valid, t_data, t_last, t_keep, output t_ready);
endinterface

// File: rtl/axis_read_interface.sv
// Reads a block of BRAM words on a start command and streams them out as one
// AXI-Stream packet, using a 2-entry skid FIFO and credit-gated read issue.
`timescale 1ns/1ps
module axis_read_interface #(
    parameter int data_width     = 512,
    parameter int counter_width  = 10,
    parameter int mem_size_depth = 1024,
    parameter int keep_width     = data_width / 8
) (
    input  logic                     axis_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [counter_width-1:0] start_addr,
    input  logic [counter_width-1:0] len,
    input  logic [keep_width-1:0]    last_keep,
    output logic                     busy,
    output logic                     done,
    axis_read_interface_if.master    axis,
    output logic                     bram_ena,
    output logic                     bram_wena,
    output logic [counter_width-1:0] bram_address,
    output logic [data_width-1:0]    bram_data,
    input  logic [data_width-1:0]    bram_dout
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN
    } state_t;

    localparam logic [counter_width-1:0] last_addr = counter_width'(mem_size_depth - 1);

    state_t                   r_state;
    state_t                   w_next_state;
    logic [counter_width-1:0] r_rd_addr;
    logic [counter_width-1:0] r_remaining;
    logic [keep_width-1:0]    r_keep;
    logic                     r_inflight;
    logic                     r_inflight_last;
    logic [data_width-1:0]    r_fifo_data [2];
    logic [1:0]               r_fifo_last;
    logic                     r_wr_ptr;
    logic                     r_rd_ptr;
    logic [1:0]               r_occupancy;
    logic                     r_done;

    logic                     w_valid;
    logic                     w_pop;
    logic                     w_head_last;
    logic [1:0]               w_level;
    logic                     w_issue;
    logic                     w_accept;

    assign w_valid     = (r_occupancy != 2'd0);
    assign w_pop       = w_valid & axis.t_ready;
    assign w_head_last = r_fifo_last[r_rd_ptr];
    // Entries the FIFO will hold next cycle if nothing new is issued now.
    assign w_level     = r_occupancy + {1'b0, r_inflight} - {1'b0, w_pop};

    always_ff @(posedge axis_clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path infers a latch.
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_accept     = 1'b0;
        busy         = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (start && !r_done) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_READ;
                end
            end
            ST_READ: begin
                if (w_level < 2'd2) begin
                    w_issue = 1'b1;
                    if (r_remaining == '0) w_next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_pop && w_head_last) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (reset) begin
            r_rd_addr       <= '0;
            r_remaining     <= '0;
            r_keep          <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
            r_fifo_last     <= '0;
            r_wr_ptr        <= 1'b0;
            r_rd_ptr        <= 1'b0;
            r_occupancy     <= '0;
            r_done          <= 1'b0;
        end else begin
            r_done <= (r_state == ST_DRAIN) && w_pop && w_head_last;
            if (w_accept) begin
                r_rd_addr   <= start_addr;
                r_remaining <= len;
                r_keep      <= last_keep;
            end
            if (w_issue) begin
                r_rd_addr   <= (r_rd_addr == last_addr) ? '0 : r_rd_addr + counter_width'(1);
                r_remaining <= r_remaining - counter_width'(1);
            end
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue && (r_remaining == '0);
            if (r_inflight) begin
                r_fifo_last[r_wr_ptr] <= r_inflight_last;
                r_wr_ptr              <= ~r_wr_ptr;
            end
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_occupancy <= w_level;
        end
    end

    // NOTE: the data slots are not reset; every output read from them is gated by w_valid.
    always_ff @(posedge axis_clk) begin
        if (r_inflight) r_fifo_data[r_wr_ptr] <= bram_dout;
    end

    assign done         = r_done;
    assign axis.t_valid = w_valid;
    assign axis.t_data  = w_valid ? r_fifo_data[r_rd_ptr] : '0;
    assign axis.t_last  = w_valid & w_head_last;
    assign axis.t_keep  = !w_valid ? '0 : (w_head_last ? r_keep : '1);
    assign bram_ena     = w_issue;
    assign bram_address = w_issue ? r_rd_addr : '0;
    assign bram_wena    = 1'b0;
    assign bram_data    = '0;

endmodule

// File: tb/tb_axis_read_interface.sv
// Scoreboard bench for axis_read_interface: expected beats and read addresses are
// queued when a packet is commanded and popped as the DUT produces them.
`timescale 1ns/1ps
module tb_axis_read_interface;

    localparam int data_width     = 512;
    localparam int counter_width  = 10;
    localparam int mem_size_depth = 1024;
    localparam int keep_width     = data_width / 8;

    typedef logic [counter_width-1:0] addr_t;
    typedef logic [keep_width-1:0]    keep_t;
    typedef struct packed {
        logic [data_width-1:0] data;
        logic                  last;
        keep_t                 keep;
    } beat_t;

    logic                  axis_clk = 1'b0;
    logic                  reset    = 1'b1;
    logic                  start    = 1'b0;
    addr_t                 start_addr = '0;
    addr_t                 len        = '0;
    keep_t                 last_keep  = '0;
    logic                  busy, done, bram_ena, bram_wena;
    addr_t                 bram_address;
    logic [data_width-1:0] bram_data;
    logic [data_width-1:0] bram_dout;
    logic [data_width-1:0] mem [mem_size_depth];

    int    vectors     = 0;
    int    miscompares = 0;
    beat_t exp_q [$];
    addr_t addr_q [$];

    axis_read_interface_if #(.data_width(data_width), .keep_width(keep_width)) axis ();

    axis_read_interface #(
        .data_width    (data_width),
        .counter_width (counter_width),
        .mem_size_depth(mem_size_depth),
        .keep_width    (keep_width)
    ) dut (
        .axis_clk    (axis_clk),
        .reset       (reset),
        .start       (start),
        .start_addr  (start_addr),
        .len         (len),
        .last_keep   (last_keep),
        .busy        (busy),
        .done        (done),
        .axis        (axis),
        .bram_ena    (bram_ena),
        .bram_wena   (bram_wena),
        .bram_address(bram_address),
        .bram_data   (bram_data),
        .bram_dout   (bram_dout)
    );

    always #5 axis_clk = ~axis_clk;

    always @(posedge axis_clk) begin
        if (bram_ena) bram_dout <= mem[bram_address];
    end

    function automatic logic ready_for(input int mode, input int n);
        if (mode == 0) return 1'b1;
        case (n % 6)
            0, 3, 5: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Commands one packet and follows it cycle by cycle until done (or abort).
    task automatic run_packet(input addr_t addr, input addr_t plen, input keep_t keep,
                              input int mode, input int abort_after, input int busy_start_n,
                              output int first_valid, output int first_hs, output int last_hs,
                              output int ena_cnt, output int beats);
        beat_t exp_b, got_b, held_b;
        addr_t a;
        int    occ_m, infl_m, pop, n;
        logic  stalled, finished, aborted;
        exp_q.delete();
        addr_q.delete();
        for (int i = 0; i <= int'(plen); i++) begin
            a          = addr + addr_t'(i);
            exp_b.data = data_width'(a);
            exp_b.last = (i == int'(plen));
            exp_b.keep = exp_b.last ? keep : '1;
            addr_q.push_back(a);
            exp_q.push_back(exp_b);
        end
        first_valid = -1; first_hs = -1; last_hs = -1; ena_cnt = 0; beats = 0;
        occ_m = 0; infl_m = 0; stalled = 1'b0; finished = 1'b0; aborted = 1'b0; held_b = '0;
        @(negedge axis_clk);
        start = 1'b1; start_addr = addr; len = plen; last_keep = keep;
        for (n = 0; n < 300 && !finished; n++) begin
            @(negedge axis_clk);
            start = 1'b0;
            if (n == busy_start_n) begin
                start = 1'b1; start_addr = addr_t'(300); len = plen;
            end
            axis.t_ready = ready_for(mode, n);
            #1;
            pop   = int'(axis.t_valid && axis.t_ready);
            got_b = {axis.t_data, axis.t_last, axis.t_keep};
            vectors++;
            if (axis.t_valid !== (occ_m != 0)) begin
                miscompares++;
                $display("FAIL t_valid n=%0d: got %b, want %b", n, axis.t_valid, occ_m != 0);
            end
            vectors++;
            if (occ_m + infl_m - pop + int'(bram_ena) > 2) begin
                miscompares++;
                $display("FAIL credit n=%0d: got level %0d, want <= 2", n, occ_m + infl_m - pop + int'(bram_ena));
            end
            if (bram_ena === 1'b1) begin
                ena_cnt++;
                vectors++;
                if (addr_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_read n=%0d: got addr %0d, want no read", n, bram_address);
                end else begin
                    a = addr_q.pop_front();
                    if (bram_address !== a) begin
                        miscompares++;
                        $display("FAIL bram_address n=%0d: got %0d, want %0d", n, bram_address, a);
                    end
                end
            end
            if (stalled) begin
                vectors++;
                if (axis.t_valid !== 1'b1 || got_b !== held_b) begin
                    miscompares++;
                    $display("FAIL stall_hold n=%0d: got data %0h last %b keep %0h, want data %0h last %b keep %0h",
                             n, got_b.data, got_b.last, got_b.keep, held_b.data, held_b.last, held_b.keep);
                end
            end
            if (first_valid < 0 && axis.t_valid === 1'b1) first_valid = n;
            if (pop != 0) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL extra_beat n=%0d: got data %0h, want none", n, got_b.data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (got_b !== exp_b) begin
                        miscompares++;
                        $display("FAIL beat n=%0d: got data %0h last %b keep %0h, want data %0h last %b keep %0h",
                                 n, got_b.data, got_b.last, got_b.keep, exp_b.data, exp_b.last, exp_b.keep);
                    end
                end
                if (first_hs < 0) first_hs = n;
                last_hs = n;
                beats++;
            end
            held_b  = got_b;
            stalled = axis.t_valid && !axis.t_ready;
            occ_m   = occ_m + infl_m - pop;
            infl_m  = int'(bram_ena);
            vectors++;
            if (done === 1'b1) begin
                if (busy !== 1'b0 || n != last_hs + 1 || exp_q.size() != 0) begin
                    miscompares++;
                    $display("FAIL done n=%0d: got busy %b last_hs %0d left %0d, want busy 0 at n=last_hs+1 left 0",
                             n, busy, last_hs, exp_q.size());
                end
                finished = 1'b1;
            end else if (busy !== 1'b1) begin
                miscompares++;
                $display("FAIL busy n=%0d: got %b, want 1", n, busy);
            end
            if (abort_after > 0 && beats == abort_after) begin
                aborted  = 1'b1;
                finished = 1'b1;
            end
        end
        vectors++;
        if (!finished) begin
            miscompares++;
            $display("FAIL timeout: got no done after %0d cycles, want done", n);
        end
        if (!aborted) begin
            @(negedge axis_clk);
            #1;
            vectors++;
            if (done !== 1'b0) begin
                miscompares++;
                $display("FAIL done_pulse: got %b one cycle later, want 0", done);
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        #1;
        vectors++;
        if ({busy, done, axis.t_valid, axis.t_last, bram_ena, bram_wena} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b, want 000000", {busy, done, axis.t_valid, axis.t_last, bram_ena, bram_wena});
        end
        vectors++;
        if (axis.t_data !== '0 || axis.t_keep !== '0 || bram_address !== '0 || bram_data !== '0) begin
            miscompares++;
            $display("FAIL reset_bus: got data %0h keep %0h addr %0d bdata %0h, want all 0",
                     axis.t_data, axis.t_keep, bram_address, bram_data);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_beat();
        int fv, fh, lh, ec, bt;
        run_packet(addr_t'(5), addr_t'(0), keep_t'(64'hFF), 0, 0, -1, fv, fh, lh, ec, bt);
        vectors++;
        if (fv != 2 || bt != 1 || ec != 1 || fh != lh) begin
            miscompares++;
            $display("FAIL single_beat: got first_valid %0d beats %0d reads %0d, want 2 1 1", fv, bt, ec);
        end
    endtask

    task automatic test_streaming();
        int fv, fh, lh, ec, bt;
        run_packet(addr_t'(0), addr_t'(9), keep_t'(64'h0F0F), 0, 0, -1, fv, fh, lh, ec, bt);
        vectors++;
        if (fv != 2 || bt != 10 || ec != 10 || lh - fh != 9) begin
            miscompares++;
            $display("FAIL streaming: got first_valid %0d beats %0d reads %0d span %0d, want 2 10 10 9",
                     fv, bt, ec, lh - fh);
        end
    endtask

    task automatic test_backpressure();
        int fv, fh, lh, ec, bt;
        run_packet(addr_t'(100), addr_t'(7), keep_t'(64'h3), 1, 0, -1, fv, fh, lh, ec, bt);
        vectors++;
        if (fv != 2 || bt != 8 || ec != 8 || fh < 0 || lh <= fh) begin
            miscompares++;
            $display("FAIL backpressure: got first_valid %0d beats %0d reads %0d, want 2 8 8", fv, bt, ec);
        end
    endtask

    task automatic test_address_wrap();
        int fv, fh, lh, ec, bt;
        run_packet(addr_t'(1022), addr_t'(3), keep_t'(64'hF0), 0, 0, -1, fv, fh, lh, ec, bt);
        vectors++;
        if (fv != 2 || bt != 4 || ec != 4 || lh - fh != 3) begin
            miscompares++;
            $display("FAIL address_wrap: got first_valid %0d beats %0d reads %0d, want 2 4 4", fv, bt, ec);
        end
    endtask

    task automatic test_reset_mid_packet();
        int fv, fh, lh, ec, bt;
        run_packet(addr_t'(0), addr_t'(20), keep_t'(64'h1), 0, 4, -1, fv, fh, lh, ec, bt);
        @(negedge axis_clk);
        reset = 1'b1;
        axis.t_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge axis_clk);
            #1;
            vectors++;
            if ({busy, done, axis.t_valid, axis.t_last, bram_ena} !== 5'b0 ||
                axis.t_data !== '0 || axis.t_keep !== '0 || bram_address !== '0) begin
                miscompares++;
                $display("FAIL reset_abort c=%0d: got ctl %b data %0h keep %0h addr %0d, want all 0",
                         c, {busy, done, axis.t_valid, axis.t_last, bram_ena}, axis.t_data, axis.t_keep, bram_address);
            end
        end
        reset = 1'b0;
        run_packet(addr_t'(50), addr_t'(1), keep_t'(64'h7), 0, 0, -1, fv, fh, lh, ec, bt);
        vectors++;
        if (fv != 2 || bt != 2 || ec != 2 || lh - fh != 1) begin
            miscompares++;
            $display("FAIL after_reset: got first_valid %0d beats %0d reads %0d, want 2 2 2", fv, bt, ec);
        end
    endtask

    task automatic test_start_while_busy();
        int fv, fh, lh, ec, bt;
        run_packet(addr_t'(10), addr_t'(4), keep_t'(64'hFFFF), 0, 0, 2, fv, fh, lh, ec, bt);
        vectors++;
        if (fv != 2 || bt != 5 || ec != 5 || lh - fh != 4) begin
            miscompares++;
            $display("FAIL start_busy: got first_valid %0d beats %0d reads %0d, want 2 5 5", fv, bt, ec);
        end
        for (int c = 0; c < 4; c++) begin
            @(negedge axis_clk);
            #1;
            vectors++;
            if ({busy, bram_ena, axis.t_valid} !== 3'b0) begin
                miscompares++;
                $display("FAIL start_busy_idle c=%0d: got busy/ena/valid %b, want 000", c, {busy, bram_ena, axis.t_valid});
            end
        end
    endtask

    initial begin
        axis.t_ready = 1'b0;
        for (int k = 0; k < mem_size_depth; k++) mem[k] = data_width'(k);
        test_reset();
        test_single_beat();
        test_streaming();
        test_backpressure();
        test_address_wrap();
        test_reset_mid_packet();
        test_start_while_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
